// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO writes; define MDU_MADD_EN for MADD/MSUB
module md_unit #(
  parameter int WIDTH = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDop,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] sprod, uprod, pend, pend_n, acc;
  logic [1:0] mode, mode_n;
  logic [WIDTH-1:0] div_b, abs_a, abs_b, uq, ur, mq, mr, sq, sr;
  logic is_mul, is_div, idle_start, go, fin;
  assign sprod = {{WIDTH{srcA[WIDTH-1]}}, srcA} * {{WIDTH{srcB[WIDTH-1]}}, srcB};
  assign uprod = {{WIDTH{1'b0}}, srcA} * {{WIDTH{1'b0}}, srcB};
  assign div_b = srcB == '0 ? WIDTH'(1) : srcB;
  assign abs_a = srcA[WIDTH-1] ? -srcA : srcA;
  assign abs_b = srcB == '0 ? WIDTH'(1) : srcB[WIDTH-1] ? -srcB : srcB;
  assign uq = srcA / div_b;
  assign ur = srcA % div_b;
  assign mq = abs_a / abs_b;
  assign mr = abs_a % abs_b;
  assign sq = srcA[WIDTH-1] ^ srcB[WIDTH-1] ? -mq : mq;
  assign sr = srcA[WIDTH-1] ? -mr : mr;
`ifdef MDU_MADD_EN
  assign is_mul = MDop[2:1] == 2'b00 || MDop[2:1] == 2'b11;
`else
  assign is_mul = MDop[2:1] == 2'b00;
`endif
  assign is_div = MDop[2:1] == 2'b01;
  assign idle_start = start && state == IDLE;
  assign go = idle_start && (is_mul || is_div);
  assign fin = state == RUN && cnt == CW'(1);
  assign busy = state == RUN;
  assign pend_n = MDop == 3'b001 ? uprod : is_div ? (MDop[0] ? {ur, uq} : {sr, sq}) : sprod;
  assign mode_n = MDop[2:1] == 2'b11 ? {1'b1, MDop[0]} : is_div && srcB == '0 ? 2'b01 : 2'b00;
  assign acc = mode == 2'b10 ? {HI, LO} + pend : mode == 2'b11 ? {HI, LO} - pend : pend;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (go ? RUN : IDLE) : (fin ? IDLE : RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pend <= '0;
      mode <= '0;
      done <= 1'b0;
      HI <= '0;
      LO <= '0;
    end else begin
      state <= state_n;
      done <= fin;
      if (go) begin
        cnt <= CW'(is_div ? DIV_CYCLES : MULT_CYCLES);
        pend <= pend_n;
        mode <= mode_n;
      end else if (busy) cnt <= cnt - CW'(1);
      if (fin && mode != 2'b01) {HI, LO} <= acc;
      else if (idle_start && MDop == 3'b100) HI <= srcA;
      else if (idle_start && MDop == 3'b101) LO <= srcA;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table-driven and scoreboard checks of md_unit
module tb_md_unit;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, busy, done;
  logic [2:0] MDop = '0;
  logic [31:0] srcA = '0, srcB = '0, HI, LO;
  logic [63:0] sb[$];
  int passed = 0, total = 0;
  typedef struct {
    logic [2:0] op;
    logic [31:0] a, b;
    int n;
    logic [31:0] eh, el;
  } vec_t;
  vec_t vecs[10];
  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDop(MDop), .srcA(srcA), .srcB(srcB),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask
  always @(negedge clk) if (done) begin
    if (sb.size() == 0) check("spurious_done", 64'(done), 64'(0));
    else begin
      logic [63:0] e;
      e = sb.pop_front();
      check("result_hi", 64'(HI), 64'(e[63:32]));
      check("result_lo", 64'(LO), 64'(e[31:0]));
    end
  end
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    start = 1'b1; MDop = op; srcA = a; srcB = b;
    sb.push_back({eh, el});
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_busy(input string nm, input int n, input int already);
    int cyc;
    cyc = already;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({nm, "_busy_len"}, 64'(cyc), 64'(n));
    @(posedge clk);
    #1;
    check({nm, "_drained"}, 64'(sb.size()), 64'(0));
    check({nm, "_done_pulse"}, 64'(done), 64'(0));
  endtask
  initial begin
    vecs[0] = '{3'b000, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1] = '{3'b001, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{3'b010, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'b011, 32'd200, 32'd7, 10, 32'd4, 32'd28};
    vecs[4] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000};
    vecs[5] = '{3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 5, 32'h3FFFFFFF, 32'h00000001};
    vecs[6] = '{3'b000, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[7] = '{3'b010, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD};
    vecs[8] = '{3'b011, 32'hFFFFFFFF, 32'd10, 10, 32'd5, 32'h19999999};
    vecs[9] = '{3'b010, 32'hFFFFFFF8, 32'hFFFFFFFD, 10, 32'hFFFFFFFE, 32'd2};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", {HI, LO}, 64'h0);
    check("reset_busy_done", {62'h0, busy, done}, 64'h0);
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);
      wait_busy($sformatf("vec%0d", i), vecs[i].n, 0);
    end
    @(negedge clk);
    start = 1'b1; MDop = 3'b100; srcA = 32'h12345678;
    @(negedge clk);
    check("mthi_hi", 64'(HI), 64'h12345678);
    check("mthi_lo_kept", 64'(LO), 64'h2);
    MDop = 3'b101; srcA = 32'h9;
    @(negedge clk);
    start = 1'b0;
    check("mtlo", {HI, LO}, 64'h12345678_00000009);
    check("mt_no_busy", {62'h0, busy, done}, 64'h0);
    issue(3'b011, 32'd5, 32'd0, 32'h12345678, 32'h9);
    wait_busy("divu_by_zero", 10, 0);
`ifndef MDU_MADD_EN
    @(negedge clk);
    start = 1'b1; MDop = 3'b110; srcA = 32'd3; srcB = 32'd4;
    @(negedge clk);
    start = 1'b0;
    check("reserved_no_busy", 64'(busy), 64'h0);
    check("reserved_no_write", {HI, LO}, 64'h12345678_00000009);
`endif
    issue(3'b000, 32'd3, 32'd4, 32'h0, 32'd12);
    @(negedge clk);
    start = 1'b1; MDop = 3'b101; srcA = 32'h55;
    @(negedge clk);
    MDop = 3'b011; srcA = 32'd100; srcB = 32'd3;
    check("run_lo_held", 64'(LO), 64'h9);
    @(negedge clk);
    start = 1'b0; srcA = 32'd7;
    wait_busy("ignored_starts", 5, 3);
    check("no_second_op", 64'(busy), 64'h0);
    issue(3'b010, 32'd100, 32'd7, 32'd2, 32'd14);
    repeat (3) @(negedge clk);
    check("reset_pre_busy", 64'(busy), 64'h1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    check("midrun_reset_regs", {HI, LO}, 64'h0);
    check("midrun_reset_busy_done", {62'h0, busy, done}, 64'h0);
    repeat (15) @(negedge clk);
    check("post_reset_idle", {62'h0, busy, done}, 64'h0);
    check("post_reset_regs", {HI, LO}, 64'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
